exec_wb_scheduler: RTL and testbench

//  Issue-side scheduler for the X (ALU, short latency) and Y (4-stage multiply) execute units sharing one register-file write port.

---
 rtl/exec_wb_scheduler_pkg.sv | 26 ++
 rtl/exec_wb_scheduler_if.sv | 35 +++
 rtl/exec_wb_slot_table.sv | 58 +++++
 rtl/exec_wb_scheduler.sv | 95 +++++++++
 tb/tb_exec_wb_scheduler.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/exec_wb_scheduler_pkg.sv
// Shared types and defaults for the X/Y execute writeback scheduler.
// A reservation slot holds {valid, unit, regdest}; unit 0 is X, unit 1 is Y.
package exec_sched_pkg;

  localparam int DEF_X_LATENCY = 1;
  localparam int DEF_Y_LATENCY = 4;
  localparam int SLOT_REG_AW   = 5;

  typedef enum logic [1:0] {
    FU_NONE = 2'd0,
    FU_X0   = 2'd1,
    FU_X1   = 2'd2,
    FU_Y    = 2'd3
  } fu_e;

  typedef struct packed {
    logic                   valid;
    logic                   unit;
    logic [SLOT_REG_AW-1:0] regdest;
  } wb_slot_t;

  function automatic logic is_x_unit(input logic [1:0] fu);
    return (fu == FU_X0) || (fu == FU_X1);
  endfunction

endpackage

// File: rtl/exec_wb_scheduler_if.sv
// Issue-stage <-> scheduler bundle: issue request, go strobes, writeback tag and perf counters.
interface exec_wb_scheduler_if #(parameter int REG_AW = 5);

  // Handshake: an op is taken in the cycle is_valid=1 and is_stall=0; while is_stall=1
  // the issue side holds every is_* input stable. is_x_go/is_y_go mark the taking cycle.
  logic              is_valid;
  logic [1:0]        is_functionalunit;
  logic              is_writereg;
  logic [REG_AW-1:0] is_regdest;
  logic [REG_AW-1:0] is_rs;
  logic [REG_AW-1:0] is_rt;

  logic              is_stall;
  logic              is_x_go;
  logic              is_y_go;
  logic              wb_valid;
  logic              wb_unit;
  logic [REG_AW-1:0] wb_regdest;
  logic [2:0]        inflight;
  logic [31:0]       perf_struct_cnt;
  logic [31:0]       perf_hazard_cnt;

  modport master (
    output is_valid, is_functionalunit, is_writereg, is_regdest, is_rs, is_rt,
    input  is_stall, is_x_go, is_y_go, wb_valid, wb_unit, wb_regdest, inflight,
    input  perf_struct_cnt, perf_hazard_cnt
  );

  modport slave (
    input  is_valid, is_functionalunit, is_writereg, is_regdest, is_rs, is_rt,
    output is_stall, is_x_go, is_y_go, wb_valid, wb_unit, wb_regdest, inflight,
    output perf_struct_cnt, perf_hazard_cnt
  );

endinterface

// File: rtl/exec_wb_slot_table.sv
// Shifting writeback reservation table. Entry 0 is the slot writing this cycle (drives wb_*),
// entry d writes d cycles from now; a reservation for latency L lands in entry L-1 at the edge.
module exec_wb_slot_table
  import exec_sched_pkg::*;
#(
  parameter int Y_LATENCY = DEF_Y_LATENCY,
  parameter int IDX_W     = $clog2(Y_LATENCY + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_res_en,
  input  logic [IDX_W-1:0]       i_res_idx,
  input  wb_slot_t               i_res_slot,
  input  logic [SLOT_REG_AW-1:0] i_rs,
  input  logic [SLOT_REG_AW-1:0] i_rt,
  input  logic [SLOT_REG_AW-1:0] i_waw_reg,
  input  logic [IDX_W-1:0]       i_waw_lat,
  output wb_slot_t               o_wb,
  output logic [Y_LATENCY-1:0]   o_slot_valid,
  output logic [Y_LATENCY-1:0]   o_raw_match,
  output logic [Y_LATENCY-1:0]   o_waw_match
);

  wb_slot_t r_slot  [Y_LATENCY];
  wb_slot_t w_above [Y_LATENCY];

  for (genvar d = 0; d < Y_LATENCY; d++) begin : g_slot
    if (d == Y_LATENCY - 1) begin : g_top
      assign w_above[d] = '0;
    end else begin : g_mid
      assign w_above[d] = r_slot[d+1];
    end

    assign o_slot_valid[d] = r_slot[d].valid;
    // The writing-now entry still blocks reads: a register is readable the cycle after its write.
    assign o_raw_match[d]  = r_slot[d].valid &&
                             (((i_rs != '0) && (r_slot[d].regdest == i_rs)) ||
                              ((i_rt != '0) && (r_slot[d].regdest == i_rt)));
    // Older writes landing after ours, and the one writing now, hold back a same-register writer.
    assign o_waw_match[d]  = r_slot[d].valid && (i_waw_reg != '0) &&
                             (r_slot[d].regdest == i_waw_reg) &&
                             ((d == 0) || (IDX_W'(d) > i_waw_lat));
  end

  always_ff @(posedge clock) begin
    for (int d = 0; d < Y_LATENCY; d++) begin
      if (reset)
        r_slot[d] <= '0;
      else if (i_res_en && (i_res_idx == IDX_W'(d + 1)))
        r_slot[d] <= i_res_slot;
      else
        r_slot[d] <= w_above[d];
    end
  end

  assign o_wb = r_slot[0];

endmodule

// File: rtl/exec_wb_scheduler.sv
// Issue-side scheduler for the X/Y execute units sharing one write port: stalls, go strobes,
// in-flight count. Optional perf counters are built when EXEC_SCHED_PERF_EN is defined.
module exec_wb_scheduler
  import exec_sched_pkg::*;
#(
  parameter int X_LATENCY = DEF_X_LATENCY,
  parameter int Y_LATENCY = DEF_Y_LATENCY,
  parameter int REG_AW    = SLOT_REG_AW
) (
  input  logic          clock,
  input  logic          reset,
  exec_wb_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(Y_LATENCY + 1);

  logic                 w_is_x, w_is_y, w_reserve_req;
  logic                 w_struct, w_raw, w_waw, w_conflict, w_accept, w_res_en;
  logic [IDX_W-1:0]     w_lat;
  wb_slot_t             w_res_slot, w_wb;
  logic [Y_LATENCY-1:0] w_slot_valid, w_raw_match, w_waw_match;
  logic [2:0]           r_inflight;

  assign w_is_x        = is_x_unit(bus.is_functionalunit);
  assign w_is_y        = (bus.is_functionalunit == FU_Y);
  assign w_reserve_req = bus.is_writereg && (w_is_x || w_is_y);
  assign w_lat         = w_is_y ? IDX_W'(Y_LATENCY) : IDX_W'(X_LATENCY);
  assign w_res_slot    = '{valid: 1'b1, unit: w_is_y, regdest: bus.is_regdest};

  exec_wb_slot_table #(.Y_LATENCY(Y_LATENCY), .IDX_W(IDX_W)) u_table (
    .clock        (clock),
    .reset        (reset),
    .i_res_en     (w_res_en),
    .i_res_idx    (w_lat),
    .i_res_slot   (w_res_slot),
    .i_rs         (bus.is_rs),
    .i_rt         (bus.is_rt),
    .i_waw_reg    (bus.is_regdest),
    .i_waw_lat    (w_lat),
    .o_wb         (w_wb),
    .o_slot_valid (w_slot_valid),
    .o_raw_match  (w_raw_match),
    .o_waw_match  (w_waw_match)
  );

  // Entry L is the slot this op would write through; the Y-latency slot is always free.
  always_comb begin
    w_struct = 1'b0;
    for (int d = 0; d < Y_LATENCY; d++)
      if (w_slot_valid[d] && (w_lat == IDX_W'(d))) w_struct = 1'b1;
    w_struct = w_struct & w_reserve_req;
  end

  assign w_raw      = |w_raw_match;
  assign w_waw      = w_reserve_req && (|w_waw_match);
  assign w_conflict = w_struct || w_raw || w_waw;
  assign w_accept   = bus.is_valid && !reset && !w_conflict;
  assign w_res_en   = w_accept && w_reserve_req;

  assign bus.is_stall   = bus.is_valid && !reset && w_conflict;
  assign bus.is_x_go    = w_accept && w_is_x;
  assign bus.is_y_go    = w_accept && w_is_y;
  assign bus.wb_valid   = w_wb.valid;
  assign bus.wb_unit    = w_wb.unit;
  assign bus.wb_regdest = w_wb.regdest;
  assign bus.inflight   = r_inflight;

  always_ff @(posedge clock) begin
    if (reset) r_inflight <= '0;
    else       r_inflight <= r_inflight + 3'(w_res_en) - 3'(w_wb.valid);
  end

`ifdef EXEC_SCHED_PERF_EN
  logic [31:0] r_perf_struct, r_perf_hazard;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_struct <= '0;
      r_perf_hazard <= '0;
    end else begin
      if (bus.is_valid && w_struct && (r_perf_struct != '1))
        r_perf_struct <= r_perf_struct + 32'd1;
      if (bus.is_valid && (w_raw || w_waw) && (r_perf_hazard != '1))
        r_perf_hazard <= r_perf_hazard + 32'd1;
    end
  end

  assign bus.perf_struct_cnt = r_perf_struct;
  assign bus.perf_hazard_cnt = r_perf_hazard;
`else
  assign bus.perf_struct_cnt = '0;
  assign bus.perf_hazard_cnt = '0;
`endif

endmodule

// File: tb/tb_exec_wb_scheduler.sv
// Directed, table-driven bench for exec_wb_scheduler: one vector per clock cycle with
// hand-computed outputs; perf counters are checked at the end of each sequence.
module tb_exec_wb_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  exec_wb_scheduler_if #(.REG_AW(5)) bus ();

  exec_wb_scheduler dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic [1:0] fu;
    logic       wr;
    logic [4:0] rd, rs, rt;
    logic       stall, xgo, ygo, wbv, wbu;
    logic [4:0] wbrd;
    logic [2:0] infl;
    logic       chk_perf;
    int         ps, ph;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add_vec(input logic r, input logic v, input logic [1:0] fu, input logic wr,
                         input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                         input logic stall, input logic xgo, input logic ygo,
                         input logic wbv, input logic wbu, input logic [4:0] wbrd,
                         input logic [2:0] infl);
    vec_t e;
    e.rst = r; e.v = v; e.fu = fu; e.wr = wr; e.rd = rd; e.rs = rs; e.rt = rt;
    e.stall = stall; e.xgo = xgo; e.ygo = ygo; e.wbv = wbv; e.wbu = wbu; e.wbrd = wbrd;
    e.infl = infl; e.chk_perf = 1'b0; e.ps = 0; e.ph = 0;
    vecs.push_back(e);
  endtask

  task automatic idle(input logic wbv, input logic wbu, input logic [4:0] wbrd, input logic [2:0] infl);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wbv, wbu, wbrd, infl);
  endtask

  task automatic rst_vec();
    add_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic perf(input int ps, input int ph);
    vecs[vecs.size()-1].chk_perf = 1'b1;
    vecs[vecs.size()-1].ps = ps;
    vecs[vecs.size()-1].ph = ph;
  endtask

  task automatic check_perf(input int idx, input int ps, input int ph);
    int ps_e, ph_e;
`ifdef EXEC_SCHED_PERF_EN
    ps_e = ps; ph_e = ph;
`else
    ps_e = 0;  ph_e = 0;
`endif
    n_checks++;
    if (bus.perf_struct_cnt === 32'(ps_e) && bus.perf_hazard_cnt === 32'(ph_e)) n_pass++;
    else $display("FAIL vec%0d perf: got struct=%0d hazard=%0d, expected struct=%0d hazard=%0d",
                  idx, bus.perf_struct_cnt, bus.perf_hazard_cnt, ps_e, ph_e);
  endtask

  initial begin
    logic [12:0] got, exp;

    // Reset-state check after the power-up reset.
    idle(0, 0, 0, 0); perf(0, 0);

    // Single Y op rd=5: go at c0, writeback at c4 only.
    rst_vec();
    add_vec(0, 1, 3, 1, 5, 0, 0,  0, 0, 1,  0, 0, 0, 0); perf(0, 0);
    idle(0, 0, 0, 1); idle(0, 0, 0, 1); idle(0, 0, 0, 1);
    idle(1, 1, 5, 1); idle(0, 0, 0, 0);

    // Write-port conflict: Y rd=3 @0, X rd=4 @3 stalls once.
    rst_vec();
    add_vec(0, 1, 3, 1, 3, 0, 0,  0, 0, 1,  0, 0, 0, 0); perf(0, 0);
    idle(0, 0, 0, 1); idle(0, 0, 0, 1);
    add_vec(0, 1, 1, 1, 4, 0, 0,  1, 0, 0,  0, 0, 0, 1);
    add_vec(0, 1, 1, 1, 4, 0, 0,  0, 1, 0,  1, 1, 3, 1);
    idle(1, 0, 4, 1); idle(0, 0, 0, 0); perf(1, 0);

    // RAW via rt=7 behind Y rd=7: stalled c1..c4 (incl. writeback cycle), taken c5.
    rst_vec();
    add_vec(0, 1, 3, 1, 7, 0, 0,  0, 0, 1,  0, 0, 0, 0); perf(0, 0);
    add_vec(0, 1, 1, 0, 8, 0, 7,  1, 0, 0,  0, 0, 0, 1);
    add_vec(0, 1, 1, 0, 8, 0, 7,  1, 0, 0,  0, 0, 0, 1);
    add_vec(0, 1, 1, 0, 8, 0, 7,  1, 0, 0,  0, 0, 0, 1);
    add_vec(0, 1, 1, 0, 8, 0, 7,  1, 0, 0,  1, 1, 7, 1);
    add_vec(0, 1, 1, 0, 8, 0, 7,  0, 1, 0,  0, 0, 0, 0);
    idle(0, 0, 0, 0); perf(0, 4);

    // WAW: X rd=9 behind Y rd=9; struct at c3, taken c5, Y then X write.
    rst_vec();
    add_vec(0, 1, 3, 1, 9, 0, 0,  0, 0, 1,  0, 0, 0, 0); perf(0, 0);
    add_vec(0, 1, 1, 1, 9, 0, 0,  1, 0, 0,  0, 0, 0, 1);
    add_vec(0, 1, 1, 1, 9, 0, 0,  1, 0, 0,  0, 0, 0, 1);
    add_vec(0, 1, 1, 1, 9, 0, 0,  1, 0, 0,  0, 0, 0, 1);
    add_vec(0, 1, 1, 1, 9, 0, 0,  1, 0, 0,  1, 1, 9, 1);
    add_vec(0, 1, 1, 1, 9, 0, 0,  0, 1, 0,  0, 0, 0, 0);
    idle(1, 0, 9, 1); idle(0, 0, 0, 0); perf(1, 3);

    // Back-to-back Y rd=1..4: no stalls, inflight peaks at 4.
    rst_vec();
    add_vec(0, 1, 3, 1, 1, 0, 0,  0, 0, 1,  0, 0, 0, 0); perf(0, 0);
    add_vec(0, 1, 3, 1, 2, 0, 0,  0, 0, 1,  0, 0, 0, 1);
    add_vec(0, 1, 3, 1, 3, 0, 0,  0, 0, 1,  0, 0, 0, 2);
    add_vec(0, 1, 3, 1, 4, 0, 0,  0, 0, 1,  0, 0, 0, 3);
    idle(1, 1, 1, 4); idle(1, 1, 2, 3); idle(1, 1, 3, 2); idle(1, 1, 4, 1);
    idle(0, 0, 0, 0); perf(0, 0);

    // Mid-flight reset at c2 (with a request that must be ignored); flushed regs no longer hazards.
    rst_vec();
    add_vec(0, 1, 3, 1, 10, 0, 0,  0, 0, 1,  0, 0, 0, 0);
    add_vec(0, 1, 3, 1, 11, 0, 0,  0, 0, 1,  0, 0, 0, 1);
    add_vec(1, 1, 3, 1, 13, 0, 0,  0, 0, 0,  0, 0, 0, 2);
    add_vec(0, 1, 2, 1, 12, 10, 11, 0, 1, 0, 0, 0, 0, 0); perf(0, 0);
    idle(1, 0, 12, 1); idle(0, 0, 0, 0); idle(0, 0, 0, 0); idle(0, 0, 0, 0);

    // Unit-0 op, non-writing X, RAW on an X writeback, invalid request with a hazard.
    rst_vec();
    add_vec(0, 1, 0, 1, 6, 0, 0,    0, 0, 0,  0, 0, 0, 0);
    add_vec(0, 1, 2, 0, 6, 0, 0,    0, 1, 0,  0, 0, 0, 0);
    idle(0, 0, 0, 0);
    add_vec(0, 1, 1, 1, 14, 0, 0,   0, 1, 0,  0, 0, 0, 0);
    add_vec(0, 1, 3, 1, 15, 14, 0,  1, 0, 0,  1, 0, 14, 1);
    add_vec(0, 1, 3, 1, 15, 14, 0,  0, 0, 1,  0, 0, 0, 0);
    add_vec(0, 0, 3, 1, 15, 15, 0,  0, 0, 0,  0, 0, 0, 1);
    idle(0, 0, 0, 1); idle(0, 0, 0, 1); idle(1, 1, 15, 1); idle(0, 0, 0, 0);

    bus.is_valid = 1'b0; bus.is_functionalunit = 2'd0; bus.is_writereg = 1'b0;
    bus.is_regdest = '0; bus.is_rs = '0; bus.is_rt = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst                   = vecs[i].rst;
      bus.is_valid          = vecs[i].v;
      bus.is_functionalunit = vecs[i].fu;
      bus.is_writereg       = vecs[i].wr;
      bus.is_regdest        = vecs[i].rd;
      bus.is_rs             = vecs[i].rs;
      bus.is_rt             = vecs[i].rt;
      @(negedge clk);
      got = {bus.is_stall, bus.is_x_go, bus.is_y_go, bus.wb_valid, bus.wb_unit,
             bus.wb_regdest, bus.inflight};
      exp = {vecs[i].stall, vecs[i].xgo, vecs[i].ygo, vecs[i].wbv, vecs[i].wbu,
             vecs[i].wbrd, vecs[i].infl};
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL vec%0d outputs {stall,xgo,ygo,wbv,wbu,wbrd,infl}: got %b_%b_%b_%b_%b_%0d_%0d expected %b_%b_%b_%b_%b_%0d_%0d",
                    i, got[12], got[11], got[10], got[9], got[8], got[7:3], got[2:0],
                    exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:3], exp[2:0]);
      if (vecs[i].chk_perf) check_perf(i, vecs[i].ps, vecs[i].ph);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
